four_bit_divider_seq: RTL and testbench
=======================================

FOUR_BIT_DIVIDER_SEQ -- requirements
Module: four_bit_divider_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: request to begin a division.
REQ-004 SHALL have port A, input, 8 bits: unsigned dividend.
REQ-005 SHALL have port B, input, 4 bits: unsigned divisor.
REQ-006 SHALL have port q, output, 8 bits: quotient, registered.
REQ-007 SHALL have port r, output, 4 bits: remainder, registered.
REQ-008 SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking valid q and r.
REQ-010 SHALL have port div_by_zero, output, 1 bit: flag for a zero-divisor result.

Function
REQ-011 SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-012 SHALL, in IDLE or DONE with start=1, capture A and B, clear the 5-bit partial remainder R and the bit counter, and enter CALC on that edge (E0).
REQ-013 SHALL ignore changes on A and B after capture.
REQ-014 SHALL, in CALC, perform one restoring-division step per edge, MSB of the dividend first:
  - T = {R[3:0], next dividend bit}.
  - If T >= {1'b0,B}: R = T - B and the quotient bit is 1.
  - Otherwise: R = T and the quotient bit is 0.
REQ-015 SHALL perform exactly 8 CALC steps (edges E1..E8), then enter DONE with q = quotient and r = R[3:0].
REQ-016 SHALL assert done for exactly one cycle, the cycle following E8, so done is high 8 cycles after the start edge.
REQ-017 SHALL return DONE to IDLE on the next edge unless start=1 (see REQ-012).
REQ-018 SHALL hold busy=1 in CALC only; busy=0 in IDLE and DONE.
REQ-019 SHALL ignore start while busy=1, with no effect on the ongoing operation.
REQ-020 SHALL hold q, r and div_by_zero stable from DONE until the next accepted start.
REQ-021 SHALL clear div_by_zero on every accepted start.
REQ-022 SHALL produce, when B=0 and the zero-divisor check of REQ-026 is not compiled in, the natural algorithm result q=8'hFF and r=A[3:0], after full latency.

Reset
REQ-023 SHALL, while rst=1, immediately force state=IDLE, q=0, r=0, busy=0, done=0, div_by_zero=0, R=0 and counter=0.
REQ-024 SHALL, on reset asserted mid-CALC, abandon the operation and produce no done pulse.
REQ-025 SHALL accept start on the first rising edge after rst deasserts.

Configuration
REQ-026 SHALL support macro DIVIDER_ZERO_DETECT_EN.
  - Defined, start with B=0: go IDLE/DONE directly to DONE at E0, skip CALC, q=8'hFF, r=A[3:0], div_by_zero=1, done pulses in the cycle after E0; busy stays 0.
  - Undefined: div_by_zero is tied to 0 and B=0 follows REQ-022.

Verification
REQ-027 SHALL cover: A=200, B=7, start pulse -> busy for 8 cycles, then done=1 with q=28, r=4.
REQ-028 SHALL cover: A=255, B=15 -> q=17, r=0; then A=5, B=9 -> q=0, r=5.
REQ-029 SHALL cover: A=100, B=0 with DIVIDER_ZERO_DETECT_EN defined -> done 1 cycle after start, q=8'hFF, r=4, div_by_zero=1. Without the macro -> done after 8 cycles, q=8'hFF, r=4, div_by_zero=0.
REQ-030 SHALL cover: start A=200, B=7, then at cycle 3 start=1 with A=9, B=3 -> ignored; result q=28, r=4.
REQ-031 SHALL cover: rst pulsed at cycle 4 of CALC -> all outputs 0, no done pulse; a new start for 81/9 -> q=9, r=0.
REQ-032 SHALL cover: start held high across DONE -> back-to-back divisions, each with a one-cycle done pulse and correct results.

Source files
------------

// File: rtl/four_bit_divider_seq.sv
// Sequential 8-bit / 4-bit unsigned restoring divider, one quotient bit per clock.
// Optional macro DIVIDER_ZERO_DETECT_EN: a zero divisor finishes at once with div_by_zero set.
module four_bit_divider_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] A,
  input  logic [3:0] B,
  output logic [7:0] q,
  output logic [3:0] r,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  localparam int unsigned DW = 8;
  localparam int unsigned VW = 4;
  localparam int unsigned RW = VW + 1;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  state_t          state_nx;
  logic [DW-1:0]   dvd;
  logic [DW-1:0]   quo;
  logic [VW-1:0]   dvs;
  logic [RW-1:0]   rem;
  logic [CW-1:0]   cnt;
  logic            busy_nx;
  logic            done_nx;

  logic            accept_c;
  logic            zero_c;
  logic            last_c;
  logic [RW-1:0]   trial_c;
  logic            fits_c;
  logic [RW-1:0]   rem_nx_c;
  logic [DW-1:0]   quo_nx_c;

  // start is only honoured outside CALC
  assign accept_c = start && (state != CALC);
  assign last_c   = (cnt == CW'(DW - 1));

`ifdef DIVIDER_ZERO_DETECT_EN
  assign zero_c = (B == '0);
`else
  assign zero_c = 1'b0;
`endif

  // One restoring step: shift in the next dividend bit, subtract when it fits
  always_comb begin
    trial_c  = {rem[VW-1:0], dvd[DW-1]};
    fits_c   = (trial_c >= {1'b0, dvs});
    rem_nx_c = fits_c ? (trial_c - {1'b0, dvs}) : trial_c;
    quo_nx_c = {quo[DW-2:0], fits_c};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = zero_c ? DONE : CALC;
      CALC: if (last_c) state_nx = DONE;
      DONE: begin
        if (start) state_nx = zero_c ? DONE : CALC;
        else       state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_nx = 1'b0;
    done_nx = 1'b0;
    if (state_nx == CALC) busy_nx = 1'b1;
    if (state_nx == DONE) done_nx = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nx;
      done <= done_nx;
    end
  end

  // Working registers and the held result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      quo <= '0;
      cnt <= '0;
      q   <= '0;
      r   <= '0;
    end else if (accept_c) begin
      dvd <= A;
      dvs <= B;
      rem <= '0;
      quo <= '0;
      cnt <= '0;
      if (zero_c) begin
        q <= '1;
        r <= A[VW-1:0];
      end
    end else if (state == CALC) begin
      dvd <= {dvd[DW-2:0], 1'b0};
      rem <= rem_nx_c;
      quo <= quo_nx_c;
      cnt <= cnt + CW'(1);
      if (last_c) begin
        q <= quo_nx_c;
        r <= rem_nx_c[VW-1:0];
      end
    end
  end

`ifdef DIVIDER_ZERO_DETECT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           div_by_zero <= 1'b0;
    else if (accept_c) div_by_zero <= zero_c;
  end
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_four_bit_divider_seq.sv
// Randomised and directed bench for four_bit_divider_seq against an arithmetic model.
// Honours DIVIDER_ZERO_DETECT_EN for the expected zero-divisor behaviour.
module tb_four_bit_divider_seq;

`ifdef DIVIDER_ZERO_DETECT_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [3:0] B;
  logic [7:0] q;
  logic [3:0] r;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int total = 0;
  int bad   = 0;

  four_bit_divider_seq dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .q(q), .r(r), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division, with the natural zero-divisor result
  task automatic model(input logic [7:0] a, input logic [3:0] b,
                       output logic [7:0] eq, output logic [3:0] er,
                       output logic ed, output int elat, output int ebusy);
    if (b == 4'd0) begin
      eq    = 8'hFF;
      er    = a[3:0];
      ed    = ZD;
      elat  = ZD ? 0 : 8;
      ebusy = ZD ? 0 : 8;
    end else begin
      eq    = 8'(int'(a) / int'(b));
      er    = 4'(int'(a) % int'(b));
      ed    = 1'b0;
      elat  = 8;
      ebusy = 8;
    end
  endtask

  task automatic launch(input logic [7:0] a, input logic [3:0] b);
    A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Edges from now until done is seen; -1 if it never arrives
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
      tick();
    end
  endtask

  task automatic check_div(input string name, input logic [7:0] a, input logic [3:0] b);
    logic [7:0] eq; logic [3:0] er; logic ed; int elat, ebusy;
    int lat, bc;
    logic [7:0] hq; logic [3:0] hr;
    model(a, b, eq, er, ed, elat, ebusy);
    launch(a, b);
    wait_done(lat, bc);
    total++;
    if (lat !== elat) begin
      bad++; $display("FAIL %s latency a=%0d b=%0d got=%0d exp=%0d", name, a, b, lat, elat);
    end
    total++;
    if (bc !== ebusy) begin
      bad++; $display("FAIL %s busy_cycles a=%0d b=%0d got=%0d exp=%0d", name, a, b, bc, ebusy);
    end
    total++;
    if (q !== eq || r !== er || div_by_zero !== ed) begin
      bad++; $display("FAIL %s result a=%0d b=%0d got q=%0d r=%0d z=%0b exp q=%0d r=%0d z=%0b",
                      name, a, b, q, r, div_by_zero, eq, er, ed);
    end
    hq = eq; hr = er;
    A = ~a; B = ~b;
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s done_pulse got done=%0b busy=%0b exp done=0 busy=0", name, done, busy);
    end
    tick(); tick();
    total++;
    if (q !== hq || r !== hr || div_by_zero !== ed) begin
      bad++; $display("FAIL %s hold got q=%0d r=%0d z=%0b exp q=%0d r=%0d z=%0b",
                      name, q, r, div_by_zero, hq, hr, ed);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; A = 8'd0; B = 4'd0;
    tick(); tick();
    total++;
    if ({q, r, busy, done, div_by_zero} !== 15'd0) begin
      bad++; $display("FAIL reset_state got q=%0d r=%0d busy=%0b done=%0b z=%0b exp all 0",
                      q, r, busy, done, div_by_zero);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    check_div("d200_7", 8'd200, 4'd7);
    check_div("d255_15", 8'd255, 4'd15);
    check_div("d5_9", 8'd5, 4'd9);
    check_div("d100_0", 8'd100, 4'd0);
    check_div("d0_1", 8'd0, 4'd1);
    check_div("d255_1", 8'd255, 4'd1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      logic [7:0] a; logic [3:0] b;
      a = 8'($urandom_range(0, 255));
      b = 4'($urandom_range(0, 15));
      check_div("rand", a, b);
    end
  endtask

  task automatic test_ignore_start();
    int lat, bc;
    launch(8'd200, 4'd7);
    tick(); tick();
    A = 8'd9; B = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL ignore_busy got=%0b exp=1", busy);
    end
    wait_done(lat, bc);
    total++;
    if (lat + 3 !== 8) begin
      bad++; $display("FAIL ignore_latency got=%0d exp=8", lat + 3);
    end
    total++;
    if (q !== 8'd28 || r !== 4'd4) begin
      bad++; $display("FAIL ignore_result got q=%0d r=%0d exp q=28 r=4", q, r);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    int seen;
    launch(8'd200, 4'd7);
    tick(); tick(); tick();
    rst = 1'b1;
    #2;
    total++;
    if ({q, r, busy, done, div_by_zero} !== 15'd0) begin
      bad++; $display("FAIL midreset_outputs got q=%0d r=%0d busy=%0b done=%0b z=%0b exp all 0",
                      q, r, busy, done, div_by_zero);
    end
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL midreset_no_done got=%0d exp=0", seen);
    end
    // Start is raised together with reset release: the first edge must take it
    rst = 1'b0; A = 8'd81; B = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat, bc);
    total++;
    if (lat !== 8 || q !== 8'd9 || r !== 4'd0) begin
      bad++; $display("FAIL after_reset got lat=%0d q=%0d r=%0d exp lat=8 q=9 r=0", lat, q, r);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] av [5];
    logic [3:0] bv [5];
    logic [7:0] eq; logic [3:0] er; logic ed; int elat, ebusy;
    int lat, bc;
    for (int i = 0; i < 5; i++) begin
      av[i] = 8'($urandom_range(0, 255));
      bv[i] = 4'($urandom_range(1, 15));
    end
    A = av[0]; B = bv[0]; start = 1'b1;
    tick();
    A = av[1]; B = bv[1];
    for (int i = 0; i < 5; i++) begin
      model(av[i], bv[i], eq, er, ed, elat, ebusy);
      wait_done(lat, bc);
      total++;
      if (lat !== elat || q !== eq || r !== er) begin
        bad++; $display("FAIL b2b_%0d got lat=%0d q=%0d r=%0d exp lat=%0d q=%0d r=%0d",
                        i, lat, q, r, elat, eq, er);
      end
      if (i == 4) start = 1'b0;
      tick();
      total++;
      if (done !== 1'b0 || busy !== (i != 4)) begin
        bad++; $display("FAIL b2b_pulse_%0d got done=%0b busy=%0b exp done=0 busy=%0b",
                        i, done, busy, (i != 4));
      end
      if (i + 2 < 5) begin
        A = av[i + 2]; B = bv[i + 2];
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
